bfj_stage_ctrl: RTL and testbench
=================================

BFJ_STAGE_CTRL -- requirements
Module: bfj_stage_ctrl

Interface
REQ-001 Parameter NBITS, default 10, SHALL set the width of each input real/imag component.
REQ-002 Parameter NPOINT, default 8, SHALL set the frame length in complex samples; it SHALL be a power of two, at least 4.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  input  1  SHALL mark in_data as valid.
REQ-006 in_ready  output  1  SHALL indicate the block accepts an input sample.
REQ-007 in_data  input  2*NBITS  SHALL carry a sample: {real, imag}, two's complement.
REQ-008 bf_in_up, bf_in_down  output  2*NBITS each  SHALL drive the external butterfly's up/down operands.
REQ-009 bf_twd  output  1  SHALL select the butterfly twiddle: 1 = W=1, 0 = W=-j.
REQ-010 bf_out_up, bf_out_down  input  2*(NBITS+1) each  SHALL return the butterfly results, {real, imag}.
REQ-011 out_valid  output  1  SHALL mark out_data as valid.
REQ-012 out_ready  input  1  SHALL indicate the consumer accepts out_data.
REQ-013 out_data  output  2*(NBITS+1)  SHALL carry a result sample, {real, imag}.
REQ-014 out_last  output  1  SHALL mark the final sample of a frame (index NPOINT-1).
REQ-015 busy  output  1  SHALL be 1 in CALC and DRAIN, 0 in LOAD.

Function
REQ-016 The FSM SHALL have exactly three states: LOAD, CALC and DRAIN.
REQ-017 Input transfer SHALL occur on an edge where in_valid and in_ready are both 1; in_ready SHALL be 1 only in LOAD.
REQ-018 In LOAD, accepted samples SHALL be written to input buffer index 0..NPOINT-1 in arrival order; the accept of index NPOINT-1 SHALL move the FSM to CALC.
REQ-019 In CALC, the block SHALL step pair counter k = 0..NPOINT/2-1, one pair per cycle, with no stalls.
REQ-020 For pair k, bf_in_up SHALL be buffer[k] and bf_in_down SHALL be buffer[k+NPOINT/2].
REQ-021 For pair k, bf_twd SHALL be 1 when k < NPOINT/4 and 0 otherwise.
REQ-022 On each CALC edge, bf_out_up SHALL be registered to result[k] and bf_out_down to result[k+NPOINT/2].
REQ-023 The edge that registers k = NPOINT/2-1 SHALL move the FSM to DRAIN.
REQ-024 Outside CALC, bf_in_up, bf_in_down and bf_twd SHALL be driven to 0.
REQ-025 In DRAIN, out_valid SHALL be 1 and out_data SHALL be result[j], for j = 0..NPOINT-1 in order.
REQ-026 j SHALL advance only on an edge where out_valid and out_ready are both 1.
REQ-027 out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-028 out_last SHALL be 1 only while j = NPOINT-1 in DRAIN.
REQ-029 The handshake at j = NPOINT-1 SHALL return the FSM to LOAD, with in_ready=1 in the next cycle.
REQ-030 Latency: out_valid SHALL first assert NPOINT/2 cycles after the edge accepting the last input sample.
REQ-031 Frames SHALL NOT overlap; input is refused (in_ready=0) throughout CALC and DRAIN.
REQ-032 The block SHALL NOT perform arithmetic on samples; result width is NBITS+1 as returned by the butterfly, and no truncation or saturation is applied.
REQ-033 All counters SHALL wrap to 0 on each state exit.

Reset
REQ-034 On an edge with rst_n=0, the block SHALL enter LOAD with all counters at 0.
REQ-035 After reset: out_valid=0, out_last=0, busy=0, bf_* outputs=0, in_ready=1 (from the cycle after the reset edge).
REQ-036 Reset asserted in any state, mid-frame, SHALL discard the partial frame without emitting further outputs; buffer contents need not be cleared.
REQ-037 rst_n SHALL take priority over any simultaneous handshake.

Verification (NBITS=10, NPOINT=8; external butterfly as defined by REQ-009/010)
REQ-038 Ramp test: inputs x[k] = (k, 0) for k = 0..7, out_ready=1 -> outputs, in order:
  - (4,0), (6,0), (8,0), (10,0)
  - (-4,0), (-4,0), (0,4), (0,4)
  - out_last on the 8th output; first out_valid 4 cycles after the last accept.
REQ-039 Extremes test: x[0]=(-512,-512), x[4]=(-512,511), all other inputs 0 -> result[0]=(-1024,-1)
  and result[4]=(0,-1023), both with no overflow.
REQ-040 Backpressure test: toggle out_ready pseudo-randomly -> out_data never changes while stalled;
  exactly 8 handshakes; order unchanged; in_ready stays 0 until after the last handshake.
REQ-041 Input gaps test: in_valid deasserted for 3 cycles mid-frame -> no spurious buffer writes; results equal the gap-free run.
REQ-042 Reset in DRAIN: assert rst_n=0 after 3 outputs -> next cycle out_valid=0 and busy=0;
  after release in_ready=1, and a fresh frame produces correct results.
REQ-043 Back-to-back frames test: two frames sent with in_valid held at 1 -> the second frame is accepted only after the first frame's out_last handshake;
  both frames' results are correct.

Source files
------------

// File: rtl/bfj_stage_ctrl.sv
// Frame controller around an external radix-2 butterfly.
// It loads one frame of NPOINT complex samples, steps the NPOINT/2 butterfly pairs
// (one per cycle) and then drains the NPOINT results through a valid/ready port.
// Samples pass through unchanged; all arithmetic is done by the external butterfly.
module bfj_stage_ctrl #(
   parameter int unsigned NBITS  = 10,
   parameter int unsigned NPOINT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*NBITS-1:0]   in_data,
   output logic [2*NBITS-1:0]   bf_in_up,
   output logic [2*NBITS-1:0]   bf_in_down,
   output logic                 bf_twd,
   input  logic [2*NBITS+1:0]   bf_out_up,
   input  logic [2*NBITS+1:0]   bf_out_down,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*NBITS+1:0]   out_data,
   output logic                 out_last,
   output logic                 busy
);

   localparam int unsigned AW = $clog2(NPOINT);
   localparam logic [AW-1:0] LastIdx  = AW'(NPOINT - 1);
   localparam logic [AW-1:0] HalfIdx  = AW'(NPOINT / 2);
   localparam logic [AW-1:0] LastPair = AW'(NPOINT / 2 - 1);
   localparam logic [AW-1:0] QuartIdx = AW'(NPOINT / 4);

   typedef enum logic [1:0] {
      StLoad,
      StCalc,
      StDrain
   } state_e;

   state_e                state_q;
   // Shared counter: sample index in LOAD, pair index k in CALC, output index j in DRAIN.
   logic [AW-1:0]         cnt_q;
   logic                  in_ready_q;
   logic                  busy_q;
   logic                  out_valid_q;
   logic                  out_last_q;

   logic [2*NBITS-1:0]    buf_mem [NPOINT];
   logic [2*NBITS+1:0]    res_mem [NPOINT];

   logic [AW-1:0]         hi_idx;
   logic                  in_accept;
   logic                  out_accept;
   logic                  in_calc;

   assign hi_idx     = cnt_q + HalfIdx;
   assign in_calc    = (state_q == StCalc);
   assign in_accept  = (state_q == StLoad) && in_valid && in_ready_q;
   assign out_accept = (state_q == StDrain) && out_valid_q && out_ready;

   // Butterfly operands are only presented while stepping pairs; zero otherwise.
   always_comb begin
      bf_in_up   = '0;
      bf_in_down = '0;
      bf_twd     = 1'b0;
      if (in_calc) begin
         bf_in_up   = buf_mem[cnt_q];
         bf_in_down = buf_mem[hi_idx];
         bf_twd     = (cnt_q < QuartIdx);
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   // Result memory is registered, so out_data is stable while a drain stalls.
   assign out_data  = out_valid_q ? res_mem[cnt_q] : '0;

   // Sample and result storage; not cleared by reset, writes are blocked while in reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (in_accept) begin
            buf_mem[cnt_q] <= in_data;
         end
         if (in_calc) begin
            res_mem[cnt_q]  <= bf_out_up;
            res_mem[hi_idx] <= bf_out_down;
         end
      end
   end

   // Control FSM with registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StLoad;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (in_accept) begin
                  if (cnt_q == LastIdx) begin
                     state_q    <= StCalc;
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            StCalc: begin
               if (cnt_q == LastPair) begin
                  state_q     <= StDrain;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDrain: begin
               if (out_accept) begin
                  if (cnt_q == LastIdx) begin
                     state_q     <= StLoad;
                     cnt_q       <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                  end else begin
                     cnt_q      <= cnt_q + 1'b1;
                     out_last_q <= (cnt_q == LastIdx - 1'b1);
                  end
               end
            end
            default: begin
               state_q <= StLoad;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bfj_stage_ctrl.sv
// Scoreboard bench for bfj_stage_ctrl with a behavioural model of the external butterfly.
module tb_bfj_stage_ctrl;

   localparam int NB = 10;
   localparam int RW = NB + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [2*NB-1:0]   in_data;
   logic [2*NB-1:0]   bf_in_up, bf_in_down;
   logic              bf_twd;
   logic [2*RW-1:0]   bf_out_up, bf_out_down;
   logic              out_valid;
   logic              out_ready;
   logic [2*RW-1:0]   out_data;
   logic              out_last;
   logic              busy;

   bfj_stage_ctrl #(.NBITS(NB), .NPOINT(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .bf_in_up    (bf_in_up),
      .bf_in_down  (bf_in_down),
      .bf_twd      (bf_twd),
      .bf_out_up   (bf_out_up),
      .bf_out_down (bf_out_down),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // External butterfly: up = a + b, down = (a - b) * W, W = 1 or -j.
   logic signed [NB-1:0] ar, ai, br, bi;
   logic signed [RW-1:0] sr, si, dr, di;
   assign ar = bf_in_up[2*NB-1:NB];
   assign ai = bf_in_up[NB-1:0];
   assign br = bf_in_down[2*NB-1:NB];
   assign bi = bf_in_down[NB-1:0];
   assign sr = {ar[NB-1], ar} + {br[NB-1], br};
   assign si = {ai[NB-1], ai} + {bi[NB-1], bi};
   assign dr = {ar[NB-1], ar} - {br[NB-1], br};
   assign di = {ai[NB-1], ai} - {bi[NB-1], bi};
   assign bf_out_up   = {sr, si};
   assign bf_out_down = bf_twd ? {dr, di} : {di, -dr};

   typedef struct packed {
      logic [2*RW-1:0] data;
      logic            last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   last_hs_cyc = 0;
   int   hs_count = 0;
   logic hold_ready = 1'b0;
   logic bp_mode = 1'b0;

   logic [2*NB-1:0] fr_ramp [8];
   logic [2*NB-1:0] fr_imag [8];
   logic [2*NB-1:0] fr_ext  [8];
   logic [2*RW-1:0] ex_ramp [8];
   logic [2*RW-1:0] ex_imag [8];
   logic [2*RW-1:0] ex_ext  [8];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2*RW-1:0] pk(input int r, input int i);
      return {r[RW-1:0], i[RW-1:0]};
   endfunction

   function automatic logic [2*NB-1:0] pin(input int r, input int i);
      return {r[NB-1:0], i[NB-1:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [2*RW-1:0] e [8]);
      exp_t x;
      for (int i = 0; i < 8; i++) begin
         x.data = e[i];
         x.last = (i == 7);
         exp_q.push_back(x);
      end
   endtask

   // Ready driver: always ready, random backpressure, or forced low.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (hold_ready)   out_ready = 1'b0;
         else if (bp_mode) out_ready = 1'($urandom_range(0, 1));
         else              out_ready = 1'b1;
      end
   end

   // Monitor: a handshake seen here completes on the following rising edge.
   logic            prev_valid = 1'b0;
   logic            stall_pend = 1'b0;
   logic [2*RW-1:0] held_data;
   logic            held_last;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_valid = 1'b0;
         stall_pend = 1'b0;
      end else begin
         if (out_valid) begin
            if (!prev_valid) chk("latency", 32'(cyc - accept_cyc), 32'd4);
            chk("drain_flags", {30'd0, in_ready, busy}, 32'd1);
            if (stall_pend) begin
               chk("stall_data", 32'(out_data), 32'(held_data));
               chk("stall_last", 32'(out_last), 32'(held_last));
            end
            if (out_ready) begin
               hs_count++;
               stall_pend = 1'b0;
               if (out_last) last_hs_cyc = cyc + 1;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_output: got %0h, expected none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", 32'(out_data), 32'(e.data));
                  chk("out_last", 32'(out_last), 32'(e.last));
               end
            end else begin
               stall_pend = 1'b1;
               held_data  = out_data;
               held_last  = out_last;
            end
         end else begin
            stall_pend = 1'b0;
         end
         prev_valid = out_valid;
      end
   end

   // Sends one frame, optionally dropping in_valid for gap_len cycles before sample gap_at.
   task automatic send_frame(input logic [2*NB-1:0] fr [8], input int gap_at, input int gap_len,
                             output int first_acc);
      logic acc;
      int   t;
      first_acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == gap_at) begin
            in_valid = 1'b0;
            repeat (gap_len) begin
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_data  = fr[i];
         acc = 1'b0;
         t   = 0;
         while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
         end
         if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: sample %0d not accepted, expected accept", i);
            return;
         end
         if (i == 0) first_acc = cyc;
         accept_cyc = cyc;
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 600) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_flags"}, {29'd0, out_valid, out_last, busy}, 32'd0);
      chk({tag, "_bf"}, 32'(bf_in_up) | 32'(bf_in_down) | 32'(bf_twd), 32'd0);
   endtask

   initial begin
      int fa, fa2, base, t;
      for (int i = 0; i < 8; i++) begin
         fr_ramp[i] = pin(i, 0);
         fr_imag[i] = pin(0, i);
         fr_ext[i]  = '0;
      end
      fr_ext[0] = pin(-512, -512);
      fr_ext[4] = pin(-512, 511);
      ex_ramp = '{pk(4, 0), pk(6, 0), pk(8, 0), pk(10, 0),
                  pk(-4, 0), pk(-4, 0), pk(0, 4), pk(0, 4)};
      ex_imag = '{pk(0, 4), pk(0, 6), pk(0, 8), pk(0, 10),
                  pk(0, -4), pk(0, -4), pk(-4, 0), pk(-4, 0)};
      ex_ext  = '{pk(-1024, -1), pk(0, 0), pk(0, 0), pk(0, 0),
                  pk(0, -1023), pk(0, 0), pk(0, 0), pk(0, 0)};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst_n = 1'b1;

      // Ramp
      push_exp(ex_ramp);
      send_frame(fr_ramp, -1, 0, fa);
      in_valid = 1'b0;
      wait_drain();
      check_idle("ramp_end");

      // Extremes
      push_exp(ex_ext);
      send_frame(fr_ext, -1, 0, fa);
      in_valid = 1'b0;
      wait_drain();

      // Backpressure
      bp_mode = 1'b1;
      base = hs_count;
      push_exp(ex_imag);
      send_frame(fr_imag, -1, 0, fa);
      in_valid = 1'b0;
      wait_drain();
      bp_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_handshakes", 32'(hs_count - base), 32'd8);

      // Input gaps
      push_exp(ex_ramp);
      send_frame(fr_ramp, 3, 3, fa);
      in_valid = 1'b0;
      wait_drain();

      // Reset while draining
      base = hs_count;
      push_exp(ex_ramp);
      send_frame(fr_ramp, -1, 0, fa);
      in_valid = 1'b0;
      t = 0;
      while (hs_count < base + 3 && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      hold_ready = 1'b1;
      chk("rst_hs_reached", 32'(hs_count - base), 32'd3);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_drain_valid", 32'(out_valid), 32'd0);
      chk("rst_drain_busy", 32'(busy), 32'd0);
      exp_q.delete();
      rst_n = 1'b1;
      hold_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_release_ready", 32'(in_ready), 32'd1);
      push_exp(ex_imag);
      send_frame(fr_imag, -1, 0, fa);
      in_valid = 1'b0;
      wait_drain();

      // Back-to-back frames with in_valid held high
      push_exp(ex_ramp);
      push_exp(ex_imag);
      send_frame(fr_ramp, -1, 0, fa);
      send_frame(fr_imag, -1, 0, fa2);
      chk("b2b_second_accept", 32'(fa2), 32'(last_hs_cyc + 1));
      in_valid = 1'b0;
      wait_drain();
      check_idle("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

endmodule
